// File: rtl/lsu_mem_arbiter_if.sv
// LSU-array <-> data-memory arbitration bundle.
// "slave" is the arbiter's view; "master" is the LSU array plus memory controller.
interface lsu_mem_arbiter_if #(
  parameter int NUM_LSUS  = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
);
  logic [NUM_LSUS-1:0]           lsu_read_valid;
  logic [NUM_LSUS*ADDR_BITS-1:0] lsu_read_address;
  logic [NUM_LSUS-1:0]           lsu_read_ready;
  logic [NUM_LSUS*DATA_BITS-1:0] lsu_read_data;
  logic [NUM_LSUS-1:0]           lsu_write_valid;
  logic [NUM_LSUS*ADDR_BITS-1:0] lsu_write_address;
  logic [NUM_LSUS*DATA_BITS-1:0] lsu_write_data;
  logic [NUM_LSUS-1:0]           lsu_write_ready;
  logic                          mem_valid;
  logic                          mem_write;
  logic [ADDR_BITS-1:0]          mem_address;
  logic [DATA_BITS-1:0]          mem_write_data;
  logic                          mem_ready;
  logic [DATA_BITS-1:0]          mem_read_data;

  modport slave (
    input  lsu_read_valid, lsu_read_address, lsu_write_valid,
           lsu_write_address, lsu_write_data, mem_ready, mem_read_data,
    output lsu_read_ready, lsu_read_data, lsu_write_ready,
           mem_valid, mem_write, mem_address, mem_write_data
  );

  modport master (
    output lsu_read_valid, lsu_read_address, lsu_write_valid,
           lsu_write_address, lsu_write_data, mem_ready, mem_read_data,
    input  lsu_read_ready, lsu_read_data, lsu_write_ready,
           mem_valid, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_LSUS LSUs.
// One transaction at a time: IDLE (grant) -> BUSY (wait mem_ready) -> DONE (ready pulse).
module lsu_mem_arbiter #(
  parameter int NUM_LSUS  = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input logic          clk,
  input logic          reset,
  lsu_mem_arbiter_if.slave bus
);
  localparam int          IDX_W = (NUM_LSUS > 1) ? $clog2(NUM_LSUS) : 1;
  localparam int unsigned N     = NUM_LSUS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant;
  logic [NUM_LSUS-1:0]  req;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  int unsigned          cand;

  logic [ADDR_BITS-1:0] rd_addr [NUM_LSUS];
  logic [ADDR_BITS-1:0] wr_addr [NUM_LSUS];
  logic [DATA_BITS-1:0] wr_data [NUM_LSUS];
  logic [DATA_BITS-1:0] rdata_q [NUM_LSUS];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      rd_addr[i] = bus.lsu_read_address[i*ADDR_BITS +: ADDR_BITS];
      wr_addr[i] = bus.lsu_write_address[i*ADDR_BITS +: ADDR_BITS];
      wr_data[i] = bus.lsu_write_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign req = bus.lsu_read_valid | bus.lsu_write_valid;

  // First requester at or after rr_ptr, wrapping modulo NUM_LSUS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!pick_found && req[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    bus.lsu_read_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.lsu_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant               <= '0;
      bus.mem_valid       <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_write_data  <= '0;
      bus.lsu_read_ready  <= '0;
      bus.lsu_write_ready <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      bus.lsu_read_ready  <= '0;
      bus.lsu_write_ready <= '0;
      case (state)
        IDLE: begin
          // Read wins when an LSU presents both; its write stays pending for a later grant.
          if (pick_found) begin
            grant              <= pick_idx;
            bus.mem_write      <= !bus.lsu_read_valid[pick_idx];
            bus.mem_address    <= bus.lsu_read_valid[pick_idx] ? rd_addr[pick_idx]
                                                               : wr_addr[pick_idx];
            bus.mem_write_data <= wr_data[pick_idx];
            bus.mem_valid      <= 1'b1;
            state              <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            if (!bus.mem_write) begin
              bus.lsu_read_ready[grant] <= 1'b1;
              rdata_q[grant]            <= bus.mem_read_data;
            end else begin
              bus.lsu_write_ready[grant] <= 1'b1;
            end
            rr_ptr <= (grant == IDX_W'(N - 1)) ? '0 : grant + IDX_W'(1);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level round-robin model.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_arbiter_if #(.NUM_LSUS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus();

  lsu_mem_arbiter #(.NUM_LSUS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // LSU-side request state
  bit            pr [N];
  bit            pw [N];
  logic [AW-1:0] ra [N];
  logic [AW-1:0] wa [N];
  logic [DW-1:0] wd [N];

  // environment memory (written from DUT outputs) and reference memory (model)
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] rdata_exp [N];

  // reference arbiter
  int            ptr;
  bit            busy;
  bit            cool;
  int            g;
  bit            g_read;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  logic [AW-1:0] last_issue_addr;
  logic          last_issue_write;
  int            grant_log[$];
  bit            read_log[$];

  int wait_target;
  int wcnt;
  int valid_cycles;
  int pulse_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.lsu_read_valid[i]              = pr[i];
      bus.lsu_write_valid[i]             = pw[i];
      bus.lsu_read_address[i*AW +: AW]   = ra[i];
      bus.lsu_write_address[i*AW +: AW]  = wa[i];
      bus.lsu_write_data[i*DW +: DW]     = wd[i];
    end
  endtask

  task automatic req_read(input int i, input logic [AW-1:0] a);
    pr[i] = 1'b1; ra[i] = a; drive();
  endtask

  task automatic req_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pw[i] = 1'b1; wa[i] = a; wd[i] = d; drive();
  endtask

  function automatic int pick(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pr[i] = 1'b0; pw[i] = 1'b0; rdata_exp[i] = '0;
    end
    ptr = 0; busy = 1'b0; cool = 1'b0; wcnt = 0;
    bus.mem_ready = 1'b0;
    drive();
  endtask

  task automatic tick();
    logic [N-1:0] rv, wv, exp_rr, exp_wr;
    logic         rdy;
    int           gi;
    rv  = bus.lsu_read_valid;
    wv  = bus.lsu_write_valid;
    rdy = bus.mem_ready;
    if (bus.mem_valid && bus.mem_ready && bus.mem_write)
      mem[bus.mem_address] = bus.mem_write_data;
    @(posedge clk);
    #1;
    exp_rr = '0;
    exp_wr = '0;
    if (busy) begin
      if (rdy) begin
        busy = 1'b0;
        cool = 1'b1;
        if (g_read) begin
          exp_rr[g]    = 1'b1;
          rdata_exp[g] = ref_mem[g_addr];
        end else begin
          exp_wr[g]       = 1'b1;
          ref_mem[g_addr] = g_data;
        end
        ptr = (g + 1) % N;
        grant_log.push_back(g);
        read_log.push_back(g_read);
        chk("done_mem_valid", bus.mem_valid, 1'b0);
      end else begin
        chk("hold_mem_valid", bus.mem_valid, 1'b1);
        chk("hold_address", bus.mem_address, g_addr);
        chk("hold_write", bus.mem_write, !g_read);
        if (!g_read) chk("hold_wdata", bus.mem_write_data, g_data);
      end
    end else if (cool) begin
      cool = 1'b0;
      chk("cool_mem_valid", bus.mem_valid, 1'b0);
    end else begin
      gi = pick(rv | wv);
      if (gi >= 0) begin
        busy   = 1'b1;
        g      = gi;
        g_read = rv[gi];
        g_addr = g_read ? ra[gi] : wa[gi];
        g_data = wd[gi];
        last_issue_addr  = bus.mem_address;
        last_issue_write = bus.mem_write;
        chk("issue_mem_valid", bus.mem_valid, 1'b1);
        chk("issue_address", bus.mem_address, g_addr);
        chk("issue_write", bus.mem_write, !g_read);
        if (!g_read) chk("issue_wdata", bus.mem_write_data, g_data);
      end else begin
        chk("idle_mem_valid", bus.mem_valid, 1'b0);
      end
    end
    chk("read_ready", bus.lsu_read_ready, exp_rr);
    chk("write_ready", bus.lsu_write_ready, exp_wr);
    for (int i = 0; i < N; i++) chk("read_data", bus.lsu_read_data[i*DW +: DW], rdata_exp[i]);
    if (bus.mem_valid) valid_cycles++;
    pulse_count += $countones(bus.lsu_read_ready) + $countones(bus.lsu_write_ready);
    // LSUs drop the completed request; memory answers after wait_target valid cycles
    for (int i = 0; i < N; i++) begin
      if (bus.lsu_read_ready[i])  pr[i] = 1'b0;
      if (bus.lsu_write_ready[i]) pw[i] = 1'b0;
    end
    if (bus.mem_valid) begin
      bus.mem_ready     = (wcnt >= wait_target);
      bus.mem_read_data = mem[bus.mem_address];
      wcnt++;
    end else begin
      bus.mem_ready     = 1'b0;
      bus.mem_read_data = $urandom;
      wcnt = 0;
    end
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (pr[i] || pw[i]) return 1'b1;
    return busy || cool;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    if (pending()) chk("timeout_idle", 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mem_valid", bus.mem_valid, 1'b0);
    chk("rst_read_ready", bus.lsu_read_ready, '0);
    chk("rst_write_ready", bus.lsu_write_ready, '0);
    chk("rst_address", bus.mem_address, '0);
    clear_model();
    @(posedge clk);
    #1;
    chk("rst_hold_valid", bus.mem_valid, 1'b0);
    chk("rst_read_data", bus.lsu_read_data, '0);
    reset = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int a = 0; a < 256; a++) begin
      v = $urandom;
      mem[a] = v;
      ref_mem[a] = v;
    end
    mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    wait_target = 0;
    bus.mem_read_data = '0;
    clear_model();

    // reset state
    @(posedge clk);
    #1;
    chk("init_mem_valid", bus.mem_valid, 1'b0);
    chk("init_mem_write", bus.mem_write, 1'b0);
    chk("init_address", bus.mem_address, '0);
    chk("init_wdata", bus.mem_write_data, '0);
    chk("init_ready", {bus.lsu_read_ready, bus.lsu_write_ready}, '0);
    chk("init_read_data", bus.lsu_read_data, '0);
    reset = 1'b1;
    tick();

    // single read, zero-wait memory
    grant_log.delete(); read_log.delete();
    req_read(2, 8'h10);
    run_until_idle(50);
    chk("sr_address", last_issue_addr, 8'h10);
    chk("sr_write", last_issue_write, 1'b0);
    chk("sr_data", bus.lsu_read_data[2*DW +: DW], 32'hDEADBEEF);
    chk("sr_grant", grant_log.size() == 1 ? grant_log[0] : -1, 2);

    // reset while BUSY; pointer must restart at 0 (was 3)
    wait_target = 20;
    req_write(3, 8'h33, 32'h1234_5678);
    tick();
    tick();
    chk("rb_busy", bus.mem_valid, 1'b1);
    apply_reset();
    wait_target = 0;
    grant_log.delete(); read_log.delete();
    req_read(1, 8'h01);
    req_read(3, 8'h03);
    run_until_idle(50);
    chk("rb_order_len", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rb_first", grant_log[0], 1);
      chk("rb_second", grant_log[1], 3);
    end
    chk("rb_abandoned", mem[8'h33] === 32'h1234_5678, 1'b0);

    // all four write at once from reset
    apply_reset();
    grant_log.delete(); read_log.delete();
    for (int i = 0; i < N; i++) req_write(i, AW'(8'h20 + i), DW'(i));
    run_until_idle(60);
    chk("aw_len", grant_log.size(), 4);
    for (int i = 0; i < N && i < grant_log.size(); i++) chk("aw_order", grant_log[i], i);
    for (int i = 0; i < N; i++) chk("aw_mem", mem[8'h20 + i], DW'(i));

    // five wait states
    wait_target = 5;
    valid_cycles = 0;
    pulse_count  = 0;
    req_read(0, 8'h21);
    run_until_idle(50);
    chk("ws_valid_cycles", valid_cycles, 6);
    chk("ws_pulses", pulse_count, 1);
    chk("ws_data", bus.lsu_read_data[0 +: DW], 32'd1);
    wait_target = 0;

    // round robin: LSU3, then LSU0 and LSU3 together
    grant_log.delete(); read_log.delete();
    req_write(3, 8'h40, 32'hA5A5_0003);
    run_until_idle(30);
    req_read(0, 8'h40);
    req_read(3, 8'h20);
    run_until_idle(50);
    chk("rr_len", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("rr_next", grant_log[1], 0);
      chk("rr_last", grant_log[2], 3);
    end
    chk("rr_data0", bus.lsu_read_data[0 +: DW], 32'hA5A5_0003);

    // read+write together: read first
    grant_log.delete(); read_log.delete();
    req_read(1, 8'h22);
    req_write(1, 8'h50, 32'h0BAD_F00D);
    run_until_idle(50);
    chk("rw_len", read_log.size(), 2);
    if (read_log.size() == 2) begin
      chk("rw_first_read", read_log[0], 1'b1);
      chk("rw_second_write", read_log[1], 1'b0);
    end
    chk("rw_mem", mem[8'h50], 32'h0BAD_F00D);

    // single requester back-to-back: one transaction every 3 cycles
    valid_cycles = 0;
    pulse_count  = 0;
    for (int t = 0; t < 30; t++) begin
      if (!pr[2] && !(busy && g == 2)) req_read(2, AW'($urandom_range(0, 15)));
      tick();
    end
    chk("b2b_pulses", pulse_count, 10);

    // random traffic with drops and wait states
    for (int t = 0; t < 3000; t++) begin
      wait_target = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        if (busy && g == i) continue;
        if (!pr[i] && !pw[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0: req_read(i, AW'($urandom_range(0, 15)));
            1: req_write(i, AW'($urandom_range(0, 15)), $urandom);
            default: begin
              req_read(i, AW'($urandom_range(0, 15)));
              req_write(i, AW'($urandom_range(0, 15)), $urandom);
            end
          endcase
        end else if ((pr[i] || pw[i]) && $urandom_range(0, 31) == 0) begin
          pr[i] = 1'b0;
          pw[i] = 1'b0;
          drive();
        end
      end
      tick();
    end
    run_until_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
